// File: rtl/bitser_acc_seq.sv
// rtl/bitser_acc_seq.sv - bit-serial slice sequencer and shift-add readout accumulator for the DCIM macro
// Optional: define SACC_RELU_EN to clamp negative column results to zero at readout.
module bitser_acc_seq #(
  parameter int COLS   = 4,
  parameter int PSUM_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    inwidth,
  input  logic                    cima_in,
  input  logic                    insigned,
  output logic [5:0]              sel,
  output logic                    cima,
  output logic                    rd_en,
  input  logic [COLS*PSUM_W-1:0]  psum_in,
  input  logic                    psum_vld,
  output logic                    busy,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [COLS*ACC_W-1:0]   acc_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]                  state;
  logic                        inw_q;
  logic                        sgn_q;
  logic [5:0]                  rcv_cnt;
  logic [5:0]                  last_idx;
  logic                        rcv_ok;
  logic [ACC_W-1:0]            acc      [COLS];
  logic [ACC_W-1:0]            acc_nxt  [COLS];
  logic [ACC_W-1:0]            sext     [COLS];
  logic [COLS*ACC_W-1:0]       res_nxt;

  assign last_idx = inw_q ? 6'd23 : 6'd11;
  assign rd_en    = (state == S_ISSUE);
  assign busy     = (state != S_IDLE);
  assign out_vld  = (state == S_HOLD);
  assign rcv_ok   = psum_vld && ((state == S_ISSUE) || (state == S_DRAIN));

  for (genvar c = 0; c < COLS; c++) begin : g_sext
    assign sext[c] = {{(ACC_W-PSUM_W){psum_in[c*PSUM_W+PSUM_W-1]}}, psum_in[c*PSUM_W +: PSUM_W]};
  end

  // MSB slice of a signed input carries negative weight, so it seeds the accumulator negated
  always_comb begin
    res_nxt = '0;
    for (int c = 0; c < COLS; c++) begin
      acc_nxt[c] = '0;
      if ((rcv_cnt == 6'd0) && sgn_q)
        acc_nxt[c] = -sext[c];
      else
        acc_nxt[c] = (acc[c] << 1) + sext[c];
`ifdef SACC_RELU_EN
      res_nxt[c*ACC_W +: ACC_W] = acc_nxt[c][ACC_W-1] ? '0 : acc_nxt[c];
`else
      res_nxt[c*ACC_W +: ACC_W] = acc_nxt[c];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sel     <= '0;
      cima    <= 1'b0;
      inw_q   <= 1'b0;
      sgn_q   <= 1'b0;
      rcv_cnt <= '0;
      acc_out <= '0;
      for (int c = 0; c < COLS; c++) acc[c] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            inw_q   <= inwidth;
            sgn_q   <= insigned;
            cima    <= cima_in;
            sel     <= '0;
            rcv_cnt <= '0;
            for (int c = 0; c < COLS; c++) acc[c] <= '0;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (sel == last_idx) state <= S_DRAIN;
          else                 sel   <= sel + 6'd1;
        end
        S_HOLD: begin
          if (out_rdy) state <= S_IDLE;
        end
        default: ;
      endcase
      // Completion overrides the issue/drain transition when the last psum lands
      if (rcv_ok) begin
        for (int c = 0; c < COLS; c++) acc[c] <= acc_nxt[c];
        rcv_cnt <= rcv_cnt + 6'd1;
        if (rcv_cnt == last_idx) begin
          state   <= S_HOLD;
          acc_out <= res_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_bitser_acc_seq.sv
// tb/tb_bitser_acc_seq.sv - directed self-checking bench for bitser_acc_seq
module tb_bitser_acc_seq;
  localparam int COLS = 4;
  localparam int PW   = 16;
  localparam int AW   = 40;

  logic clk = 0;
  logic rst_n = 0;
  logic start = 0, inwidth = 0, cima_in = 0, insigned = 0;
  logic [5:0] sel;
  logic cima, rd_en, busy, out_vld;
  logic out_rdy = 0;
  logic psum_vld = 0;
  logic [COLS*PW-1:0] psum_in = '0;
  logic [COLS*AW-1:0] acc_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  int mode = 1;
  int delay = 1;

  typedef struct { int due; int slice; } rsp_t;
  rsp_t q[$];
  rsp_t item;

  bitser_acc_seq #(.COLS(COLS), .PSUM_W(PW), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inwidth(inwidth), .cima_in(cima_in),
    .insigned(insigned), .sel(sel), .cima(cima), .rd_en(rd_en), .psum_in(psum_in),
    .psum_vld(psum_vld), .busy(busy), .out_vld(out_vld), .out_rdy(out_rdy), .acc_out(acc_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] psum_of(int m, int slice, int c);
    if (m == 1) return 16'd1;
    if (m == 2) return (slice == 0) ? 16'd1 : 16'd0;
    if (c == 0) return 16'hFFFE;
    if (c == 1) return 16'd5;
    return 16'd0;
  endfunction

  // Array model: returns each issued slice 'delay' cycles after its rd_en
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      psum_vld = 0;
      psum_in = '0;
    end else begin
      if (rd_en) q.push_back('{cyc + delay, int'(sel)});
      psum_vld = 0;
      psum_in = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        item = q.pop_front();
        psum_vld = 1;
        for (int c = 0; c < COLS; c++) psum_in[c*PW +: PW] = psum_of(mode, item.slice, c);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] col(int c);
    return acc_out[c*AW +: AW];
  endfunction

  task automatic do_start(input logic w, input logic c, input logic s);
    @(negedge clk);
    inwidth = w; cima_in = c; insigned = s; start = 1;
    t0 = cyc;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_vld();
    int n = 0;
    while (!out_vld && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("vld_timeout", out_vld, 1);
  endtask

  task automatic release_out();
    out_rdy = 1;
    @(negedge clk);
    out_rdy = 0;
    check("idle_busy", busy, 0);
  endtask

  initial begin
    #1;
    check("rst_sel", sel, 0);
    check("rst_cima", cima, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_acc_out", acc_out[63:0], 0);
    @(negedge clk);
    rst_n = 1;

    // Unsigned 12-bit, all ones
    mode = 1; delay = 1;
    do_start(0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      check("s1_rd_en", rd_en, 1);
      check("s1_sel", sel, 64'(i));
      @(negedge clk);
    end
    check("s1_drain_rd_en", rd_en, 0);
    check("s1_drain_sel", sel, 11);
    wait_vld();
    check("s1_latency", 64'(cyc - t0), 14);
    for (int c = 0; c < COLS; c++) check("s1_col", col(c), 40'd4095);
    release_out();

    // Signed 24-bit, only MSB slice set
    mode = 2; delay = 1;
    do_start(1, 0, 1);
    wait_vld();
    check("s2_latency", 64'(cyc - t0), 26);
    for (int c = 0; c < COLS; c++) check("s2_col", col(c), 40'hFF_FF80_0000);
    release_out();

    // Mixed signs with a 3-cycle array
    mode = 3; delay = 3;
    do_start(0, 0, 1);
    wait_vld();
    check("s3_col0", col(0), 40'd2);
`ifdef SACC_RELU_EN
    check("s3_col1", col(1), 40'd0);
`else
    check("s3_col1", col(1), 40'hFF_FFFF_FFFB);
`endif
    check("s3_col2", col(2), 40'd0);
    release_out();

    // Backpressure, start blocking, cima latching
    mode = 1; delay = 1;
    do_start(0, 1, 0);
    for (int n = 0; n < 200 && !out_vld; n++) begin
      cima_in = ~cima_in;
      check("s4_cima_run", cima, 1);
      @(negedge clk);
    end
    check("s4_vld", out_vld, 1);
    for (int i = 0; i < 6; i++) begin
      start = (i == 2);
      check("s4_hold_vld", out_vld, 1);
      check("s4_hold_busy", busy, 1);
      check("s4_hold_rd_en", rd_en, 0);
      check("s4_hold_cima", cima, 1);
      check("s4_hold_col0", col(0), 40'd4095);
      @(negedge clk);
    end
    start = 1;
    out_rdy = 1;
    @(negedge clk);
    start = 0;
    out_rdy = 0;
    check("s4_idle_busy", busy, 0);
    check("s4_idle_vld", out_vld, 0);
    check("s4_idle_col0", col(0), 40'd4095);
    @(negedge clk);
    check("s4_no_restart_busy", busy, 0);
    check("s4_no_restart_rd_en", rd_en, 0);

    // Reset mid-run after slice 5
    do_start(0, 1, 0);
    for (int n = 0; n < 50 && !(rd_en && sel == 5); n++) @(negedge clk);
    check("s5_sel5", sel, 5);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("s5_rst_sel", sel, 0);
    check("s5_rst_cima", cima, 0);
    check("s5_rst_rd_en", rd_en, 0);
    check("s5_rst_busy", busy, 0);
    check("s5_rst_vld", out_vld, 0);
    check("s5_rst_acc", acc_out[63:0], 0);
    @(negedge clk);
    #1 rst_n = 1;
    do_start(0, 0, 0);
    wait_vld();
    check("s5_latency", 64'(cyc - t0), 14);
    for (int c = 0; c < COLS; c++) check("s5_col", col(c), 40'd4095);
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
